// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous-read data RAM between the MIPS32 MEM
// stage and a loader/debug port. One RAM access per cycle, read data is
// routed back to its owner one cycle later, and a starvation counter gives
// the loader a guaranteed slot when the pipeline keeps the RAM busy.
module dmem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [31:0]       mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_stall,
    output logic              mem_rvalid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_misalign,

    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,

    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_PIPE = 2'd1,
        OWN_LOAD = 2'd2
    } owner_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [3:0] STARVE_SAT = 4'd15;

    owner_e      rdOwner_q, rdOwner_d;
    logic [3:0]  starveCnt_q, starveCnt_d;
    logic        forceLd_q, forceLd_d;

    logic        pipeGrant;
    logic        loadGrant;
    logic        unusedAddrHi;

    // Byte-address bits above the RAM word index do not select anything.
    assign unusedAddrHi = ^mem_addr[31:ADDR_W+2];

    // Pick at most one requester: a forced loader slot beats the pipeline,
    // the pipeline beats an unforced loader, and nothing is granted in reset.
    always_comb begin
        pipeGrant = 1'b0;
        loadGrant = 1'b0;
        if (!rst) begin
            if (forceLd_q && ld_req) begin
                loadGrant = 1'b1;
            end else if (mem_req) begin
                pipeGrant = 1'b1;
            end else if (ld_req) begin
                loadGrant = 1'b1;
            end
        end
    end

    // Steer the RAM port from the winner; a misaligned pipeline access is
    // consumed without touching the RAM so the pipeline can trap on it.
    always_comb begin
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_wdata    = '0;
        mem_misalign = 1'b0;
        if (loadGrant) begin
            ram_en    = 1'b1;
            ram_we    = ld_we;
            ram_addr  = ld_addr;
            ram_wdata = ld_wdata;
        end else if (pipeGrant) begin
            if (mem_addr[1:0] != 2'b00) begin
                mem_misalign = 1'b1;
            end else begin
                ram_en    = 1'b1;
                ram_we    = mem_we;
                ram_addr  = mem_addr[ADDR_W+1:2];
                ram_wdata = mem_wdata;
            end
        end
    end

    // Remember who owns next cycle's read data and track how long the loader
    // has been waiting; reaching the limit reserves the next slot for it.
    always_comb begin
        rdOwner_d   = OWN_NONE;
        starveCnt_d = 4'd0;
        if (ram_en && !ram_we) begin
            rdOwner_d = loadGrant ? OWN_LOAD : OWN_PIPE;
        end
        if (ld_req && !loadGrant) begin
            starveCnt_d = (starveCnt_q == STARVE_SAT) ? STARVE_SAT : starveCnt_q + 4'd1;
        end
        forceLd_d = (starveCnt_d >= STARVE_LIM);
    end

    // State register; reset drops any read that is still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdOwner_q   <= OWN_NONE;
            starveCnt_q <= 4'd0;
            forceLd_q   <= 1'b0;
        end else begin
            rdOwner_q   <= rdOwner_d;
            starveCnt_q <= starveCnt_d;
            forceLd_q   <= forceLd_d;
        end
    end

    // Handshake outputs and read-data routing to the owning requester.
    always_comb begin
        mem_stall  = mem_req && !pipeGrant;
        ld_gnt     = loadGrant;
        mem_rvalid = !rst && (rdOwner_q == OWN_PIPE);
        ld_rvalid  = !rst && (rdOwner_q == OWN_LOAD);
        mem_rdata  = mem_rvalid ? ram_rdata : '0;
        ld_rdata   = ld_rvalid ? ram_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table for the documented scenarios, then
// randomized traffic compared against a behavioural model of the arbiter.
`timescale 1ns/1ps
module tb_dmem_arbiter;

   localparam int ADDR_W     = 10;
   localparam int DATA_W     = 32;
   localparam int STARVE_MAX = 4;
   localparam int DEPTH      = 1 << ADDR_W;

   typedef struct packed {
      logic              rst;
      logic              mReq;
      logic              mWe;
      logic [31:0]       mAddr;
      logic [DATA_W-1:0] mWdata;
      logic              lReq;
      logic              lWe;
      logic [ADDR_W-1:0] lAddr;
      logic [DATA_W-1:0] lWdata;
   } stim_t;

   typedef struct packed {
      stim_t             s;
      logic              en;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic              stall;
      logic              gnt;
      logic              mis;
      logic              mv;
      logic [DATA_W-1:0] md;
      logic              lv;
      logic [DATA_W-1:0] ld;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              mem_req, mem_we;
   logic [31:0]       mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_stall, mem_rvalid, mem_misalign;
   logic [DATA_W-1:0] mem_rdata;
   logic              ld_req, ld_we, ld_gnt, ld_rvalid;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_wdata, ld_rdata;
   logic              ram_en, ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata, ram_rdata;

   int testsRun    = 0;
   int testsFailed = 0;
   int cycleNo     = 0;

   // Behavioural model state: loader wait count, pending read, memory image.
   int                denied;
   logic              pendPipe, pendLoad;
   logic [DATA_W-1:0] pendData;
   logic [DATA_W-1:0] refMem [DEPTH];
   logic              lastGrantPipe, lastGrantLd;

   logic              ramClear;
   logic [DATA_W-1:0] ramArray [DEPTH];

   // 100 MHz free-running clock.
   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst(rst),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_stall(mem_stall), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .mem_misalign(mem_misalign),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   // Synchronous-read RAM the arbiter drives; cleared once at start-up.
   always @(posedge clk) begin
      if (ramClear) begin
         for (int i = 0; i < DEPTH; i++) ramArray[i] <= '0;
      end else if (ram_en) begin
         if (ram_we) ramArray[ram_addr] <= ram_wdata;
         else        ram_rdata <= ramArray[ram_addr];
      end
   end

   function automatic stim_t mkStim(input logic r, input logic mq, input logic mw,
                                    input logic [31:0] ma, input logic [31:0] mdat,
                                    input logic lq, input logic lw,
                                    input logic [ADDR_W-1:0] la, input logic [31:0] ldat);
      stim_t s;
      s.rst = r; s.mReq = mq; s.mWe = mw; s.mAddr = ma; s.mWdata = mdat;
      s.lReq = lq; s.lWe = lw; s.lAddr = la; s.lWdata = ldat;
      return s;
   endfunction

   function automatic vec_t mkVec(input stim_t s, input logic en, input logic we,
                                  input logic [ADDR_W-1:0] addr, input logic stall,
                                  input logic gnt, input logic mis, input logic mv,
                                  input logic [31:0] md, input logic lv, input logic [31:0] ld);
      vec_t v;
      v.s = s; v.en = en; v.we = we; v.addr = addr; v.stall = stall; v.gnt = gnt;
      v.mis = mis; v.mv = mv; v.md = md; v.lv = lv; v.ld = ld;
      return v;
   endfunction

   // Drive one cycle's worth of inputs.
   task automatic applyStimulus(input stim_t s);
      rst       = s.rst;
      mem_req   = s.mReq;
      mem_we    = s.mWe;
      mem_addr  = s.mAddr;
      mem_wdata = s.mWdata;
      ld_req    = s.lReq;
      ld_we     = s.lWe;
      ld_addr   = s.lAddr;
      ld_wdata  = s.lWdata;
   endtask

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s at cycle %0d: got 0x%h, expected 0x%h", name, cycleNo, act, exp);
      end
   endtask

   // Predict this cycle's outputs from the arbitration rules, compare, then
   // advance the model across the clock edge.
   task automatic checkModelAndAdvance();
      logic grantLd, grantPipe, mis, access, expWe, rstNow, ldReqNow;
      logic [ADDR_W-1:0] expAddr;
      logic [DATA_W-1:0] expWdata;
      grantLd = 1'b0;
      grantPipe = 1'b0;
      rstNow = rst;
      ldReqNow = ld_req;
      if (!rst) begin
         if (ld_req && denied >= STARVE_MAX) grantLd = 1'b1;
         else if (mem_req)                   grantPipe = 1'b1;
         else if (ld_req)                    grantLd = 1'b1;
      end
      mis = grantPipe && (mem_addr % 4 != 0);
      access = grantLd || (grantPipe && !mis);
      expWe = 1'b0;
      expAddr = '0;
      expWdata = '0;
      if (access) begin
         if (grantLd) begin
            expWe = ld_we; expAddr = ld_addr; expWdata = ld_wdata;
         end else begin
            expWe = mem_we; expAddr = ADDR_W'(mem_addr / 4); expWdata = mem_wdata;
         end
      end
      checkOutput("model.ram_en", ram_en, access);
      checkOutput("model.ram_we", ram_we, expWe);
      checkOutput("model.ram_addr", ram_addr, expAddr);
      checkOutput("model.ram_wdata", ram_wdata, expWdata);
      checkOutput("model.ld_gnt", ld_gnt, grantLd);
      checkOutput("model.mem_stall", mem_stall, mem_req && !grantPipe);
      checkOutput("model.mem_misalign", mem_misalign, mis);
      checkOutput("model.mem_rvalid", mem_rvalid, !rstNow && pendPipe);
      checkOutput("model.mem_rdata", mem_rdata, (!rstNow && pendPipe) ? pendData : '0);
      checkOutput("model.ld_rvalid", ld_rvalid, !rstNow && pendLoad);
      checkOutput("model.ld_rdata", ld_rdata, (!rstNow && pendLoad) ? pendData : '0);
      lastGrantPipe = grantPipe;
      lastGrantLd = grantLd;
      @(posedge clk);
      if (access && !expWe) pendData = refMem[expAddr];
      if (access && expWe) refMem[expAddr] = expWdata;
      pendPipe = access && !expWe && grantPipe;
      pendLoad = access && !expWe && grantLd;
      if (rstNow) denied = 0;
      else if (ldReqNow && !grantLd) denied = (denied < 15) ? denied + 1 : 15;
      else denied = 0;
      #1;
      cycleNo++;
   endtask

   // Apply one table vector, check its hand-written expectations and the model.
   task automatic runVector(input vec_t v, input int idx);
      applyStimulus(v.s);
      #2;
      checkOutput($sformatf("vec%0d.ram_en", idx), ram_en, v.en);
      checkOutput($sformatf("vec%0d.ram_we", idx), ram_we, v.we);
      checkOutput($sformatf("vec%0d.ram_addr", idx), ram_addr, v.addr);
      checkOutput($sformatf("vec%0d.mem_stall", idx), mem_stall, v.stall);
      checkOutput($sformatf("vec%0d.ld_gnt", idx), ld_gnt, v.gnt);
      checkOutput($sformatf("vec%0d.mem_misalign", idx), mem_misalign, v.mis);
      checkOutput($sformatf("vec%0d.mem_rvalid", idx), mem_rvalid, v.mv);
      checkOutput($sformatf("vec%0d.mem_rdata", idx), mem_rdata, v.md);
      checkOutput($sformatf("vec%0d.ld_rvalid", idx), ld_rvalid, v.lv);
      checkOutput($sformatf("vec%0d.ld_rdata", idx), ld_rdata, v.ld);
      checkModelAndAdvance();
   endtask

   // Main sequence: directed table, then randomized held-request traffic.
   initial begin
      vec_t  vecs[$];
      stim_t rs, idle, cont, cur;
      rs   = mkStim(1, 1, 0, 32'h0, 32'h0, 1, 0, 10'd0, 32'h0);
      idle = mkStim(0, 0, 0, 32'h0, 32'h0, 0, 0, 10'd0, 32'h0);
      cont = mkStim(0, 1, 0, 32'h20, 32'h0, 1, 0, 10'd7, 32'h0);

      for (int i = 0; i < 3; i++)
         vecs.push_back(mkVec(rs, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(mkStim(0, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0), 1, 1, 4, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(mkStim(0, 1, 0, 32'h10, 32'h0, 0, 0, 0, 0), 1, 0, 4, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(idle, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0));
      vecs.push_back(mkVec(mkStim(0, 0, 0, 0, 0, 1, 1, 10'd7, 32'h12345678), 1, 1, 7, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(mkStim(0, 1, 0, 32'h1C, 32'h0, 0, 0, 0, 0), 1, 0, 7, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(idle, 0, 0, 0, 0, 0, 0, 1, 32'h12345678, 0, 0));
      vecs.push_back(mkVec(mkStim(0, 1, 0, 32'h13, 32'h0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mkVec(idle, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(mkStim(0, 0, 0, 0, 0, 1, 0, 10'd7, 32'h0), 1, 0, 7, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(mkStim(1, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(idle, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(mkStim(0, 0, 0, 0, 0, 1, 1, 10'd8, 32'hA5A50008), 1, 1, 8, 0, 1, 0, 0, 0, 0, 0));
      // Ten cycles of continuous contention: loader forced in on cycles 5 and 10.
      vecs.push_back(mkVec(cont, 1, 0, 8, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++)
         vecs.push_back(mkVec(cont, 1, 0, 8, 0, 0, 0, 1, 32'hA5A50008, 0, 0));
      vecs.push_back(mkVec(cont, 1, 0, 7, 1, 1, 0, 1, 32'hA5A50008, 0, 0));
      vecs.push_back(mkVec(cont, 1, 0, 8, 0, 0, 0, 0, 0, 1, 32'h12345678));
      for (int i = 0; i < 3; i++)
         vecs.push_back(mkVec(cont, 1, 0, 8, 0, 0, 0, 1, 32'hA5A50008, 0, 0));
      vecs.push_back(mkVec(cont, 1, 0, 7, 1, 1, 0, 1, 32'hA5A50008, 0, 0));
      vecs.push_back(mkVec(idle, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678));

      ramClear = 1'b1;
      denied = 0;
      pendPipe = 1'b0;
      pendLoad = 1'b0;
      pendData = '0;
      lastGrantPipe = 1'b0;
      lastGrantLd = 1'b0;
      for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
      applyStimulus(rs);
      @(posedge clk);
      #1;
      ramClear = 1'b0;

      foreach (vecs[i]) runVector(vecs[i], i);

      cur = idle;
      for (int n = 0; n < 3000; n++) begin
         if (!cur.mReq || lastGrantPipe) begin
            cur.mReq   = ($urandom_range(0, 99) < 60);
            cur.mWe    = ($urandom_range(0, 1) == 1);
            cur.mAddr  = ($urandom() & 32'hFFFF_F03C) |
                         (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 32'h0);
            cur.mWdata = $urandom();
         end
         if (!cur.lReq || lastGrantLd) begin
            cur.lReq   = ($urandom_range(0, 99) < 50);
            cur.lWe    = ($urandom_range(0, 1) == 1);
            cur.lAddr  = ADDR_W'($urandom_range(0, 15));
            cur.lWdata = $urandom();
         end
         cur.rst = ($urandom_range(0, 99) == 0);
         applyStimulus(cur);
         #2;
         checkModelAndAdvance();
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-memory arbiter and sequencer for the MIPS32 pipeline. Shares one synchronous-read data RAM between the MEM stage (load/store from the pipeline) and a loader/debug port used to preload or inspect memory. Issues at most one RAM access per cycle, returns read data one cycle later to whichever requester owns it, stalls the pipeline when it loses arbitration, and guarantees the loader bounded latency through a starvation counter.

## Interface
- ADDR_W, 10, RAM word-address width (depth = 2^ADDR_W words)
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive loader denials (range 1..15) before the loader is forced a slot
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- mem_req  in  1  MEM stage requests an access (held until granted)
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  32  byte address (ALU result); word index = mem_addr[ADDR_W+1:2]
- mem_wdata  in  DATA_W  store data
- mem_stall  out  1  pipeline must freeze IF..MEM this cycle
- mem_rvalid  out  1  mem_rdata valid (load issued previous cycle)
- mem_rdata  out  DATA_W  load data
- mem_misalign  out  1  pulse: granted pipeline access had mem_addr[1:0] != 0
- ld_req, ld_we  in  1  loader request / write enable (held until ld_gnt)
- ld_addr  in  ADDR_W  loader word address
- ld_wdata  in  DATA_W  loader write data
- ld_gnt  out  1  loader access issued this cycle
- ld_rvalid  out  1  ld_rdata valid
- ld_rdata  out  DATA_W  loader read data
- ram_en, ram_we  out  1  RAM enable / write enable
- ram_addr  out  ADDR_W  RAM word address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid cycle after ram_en && !ram_we

## Operation
- Registered state: starve_cnt (4 bits), rd_owner (NONE/PIPE/LOAD), force_ld flag.
- Grant decision (combinational, each cycle):
  - force_ld && ld_req -> loader granted.
  - else mem_req -> pipeline granted.
  - else ld_req -> loader granted.
  - else idle: ram_en = 0.
- mem_stall = mem_req && !pipe_grant. ld_gnt = load_grant.
- Misaligned pipeline access: counts as granted (no stall), ram_en forced 0, mem_misalign = 1 that cycle, no mem_rvalid follows.
- ram_* driven combinationally from the granted requester; ram_wdata = 0 when idle.
- rd_owner <= PIPE/LOAD when a granted, enabled access is a read; else NONE.
- mem_rvalid = (rd_owner == PIPE); ld_rvalid = (rd_owner == LOAD); both rdata outputs = ram_rdata when their valid is high, else 0.
- Starvation: if ld_req && !load_grant, starve_cnt increments (saturates at 15); on load_grant or !ld_req it clears to 0. force_ld <= (next starve_cnt >= STARVE_MAX). force_ld clears when loader is granted or ld_req drops.
- Writes complete in the grant cycle; no response pulse.

## Timing
- Reset: all outputs 0 except combinational ones derived from inputs (mem_stall = mem_req since rst forces no grant); starve_cnt = 0, rd_owner = NONE, force_ld = 0. While rst high: ram_en = 0, no grants.
- Read latency: grant in cycle N -> rvalid and data in cycle N+1, exactly one cycle, no back-pressure.
- Back-to-back reads from alternating owners each return in order, one per cycle.
- Simultaneous requests: pipeline wins unless force_ld set; with STARVE_MAX = k and both requesting continuously, loader granted on every (k+1)th cycle, pipeline stalled that cycle.
- Reset asserted mid-read: pending rvalid suppressed (rd_owner cleared), no data delivered.

## Test plan
- Reset: rst high 3 cycles with mem_req=1, ld_req=1 -> ram_en=0, ld_gnt=0, mem_stall=1, both rvalid=0.
- Pipeline store 0xDEADBEEF to byte addr 0x10, then load 0x10 -> ram_addr=4, ram_we=1; next access mem_rvalid=1 one cycle after grant with 0xDEADBEEF; mem_stall=0 throughout.
- Loader write addr 7 = 0x12345678, pipeline load byte addr 0x1C -> pipeline reads 0x12345678; ld_rvalid never set.
- Contention, STARVE_MAX=4, both requesting reads for 10 cycles -> ld_gnt high in cycles 5 and 10 only, mem_stall high exactly those cycles, responses route to correct owner.
- Misaligned load addr 0x13 -> mem_misalign=1, ram_en=0, mem_stall=0, no mem_rvalid next cycle.
- rst asserted the cycle after a granted loader read -> ld_rvalid stays 0, starve_cnt=0 afterwards.
